// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin shared-register write arbiter.
package reg_arb_pkg;

    typedef enum logic {ARB, LOCKED} arb_state_t;

    // Widest requester vector the onehot helper can produce; callers slice it down.
    localparam int unsigned MaxReq = 32;

    function automatic logic [MaxReq-1:0] onehot(input int unsigned idx);
        logic [MaxReq-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned k;
            k = (32'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                idx_o    = PW'(k);
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register among NUM_REQ writers, with bounded lock bursts.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         lock_i,
    input  logic [NUM_REQ*DATA_W-1:0]  data_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [DATA_W-1:0]          q_o,
    output logic                       q_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       locked_o
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_LOCK) + 1;

    arb_state_t        state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     owner_q;
    logic [CW-1:0]     lock_cnt_q;
    logic [DATA_W-1:0] q_q;
    logic              q_valid_q;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [PW-1:0]      rr_idx;
    logic               rr_any;

    logic [MaxReq-1:0]  owner_oh_full;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      gnt_idx_inc;
    logic               gnt_any;
    logic [DATA_W-1:0]  wr_data;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req_i(req_i),
        .ptr_i(ptr_q),
        .gnt_o(rr_gnt),
        .idx_o(rr_idx),
        .any_o(rr_any)
    );

    // In LOCKED the grant index is always the owner, so one incrementer serves both states.
    always_comb begin
        owner_oh_full = onehot(32'(owner_q));
        if (state_q == ARB) begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
            gnt_any = rr_any;
        end else begin
            gnt_any = req_i[owner_q];
            gnt_idx = owner_q;
            gnt     = gnt_any ? owner_oh_full[NUM_REQ-1:0] : '0;
        end
        gnt_idx_inc = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        wr_data     = data_i[gnt_idx*DATA_W +: DATA_W];
    end

    assign gnt_o     = reset ? '0 : gnt;
    assign q_o       = q_q;
    assign q_valid_o = q_valid_q;
    assign owner_o   = owner_q;
    assign locked_o  = (state_q == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            q_valid_q <= gnt_any;
            if (gnt_any) begin
                q_q     <= wr_data;
                owner_q <= gnt_idx;
            end
            unique case (state_q)
                ARB: begin
                    if (gnt_any) begin
                        if (lock_i[gnt_idx]) begin
                            state_q    <= LOCKED;
                            lock_cnt_q <= CW'(1);
                        end else begin
                            ptr_q <= gnt_idx_inc;
                        end
                    end
                end
                LOCKED: begin
                    // Bubble, voluntary unlock, or burst limit all hand the pointer past the owner.
                    if (!gnt_any || !lock_i[owner_q] || lock_cnt_q == CW'(MAX_LOCK - 1)) begin
                        state_q    <= ARB;
                        lock_cnt_q <= '0;
                        ptr_q      <= gnt_idx_inc;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (NUM_REQ=4, DATA_W=8, MAX_LOCK=4).
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_i = 4'b1111;
    logic [3:0]  lock_i = 4'b0000;
    logic [31:0] data_i = 32'h0;
    logic [3:0]  gnt_o;
    logic [7:0]  q_o;
    logic        q_valid_o;
    logic [1:0]  owner_o;
    logic        locked_o;

    typedef struct packed {
        logic       v;
        logic [7:0] q;
        logic [1:0] own;
        logic       lk;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] D  = 32'h44332211;
    localparam logic [31:0] D2 = 32'hD4C3B2A1;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .NUM_REQ(4),
        .DATA_W(8),
        .MAX_LOCK(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_i(req_i),
        .lock_i(lock_i),
        .data_i(data_i),
        .gnt_o(gnt_o),
        .q_o(q_o),
        .q_valid_o(q_valid_o),
        .owner_o(owner_o),
        .locked_o(locked_o)
    );

    // Monitor: pops the response expected after each clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (q_valid_o !== e.v) begin
                    n_err++;
                    $display("FAIL q_valid: got %b want %b at %0t", q_valid_o, e.v, $time);
                end
                n_vec++;
                if (q_o !== e.q) begin
                    n_err++;
                    $display("FAIL q: got %h want %h at %0t", q_o, e.q, $time);
                end
                n_vec++;
                if (owner_o !== e.own) begin
                    n_err++;
                    $display("FAIL owner: got %0d want %0d at %0t", owner_o, e.own, $time);
                end
                n_vec++;
                if (locked_o !== e.lk) begin
                    n_err++;
                    $display("FAIL locked: got %b want %b at %0t", locked_o, e.lk, $time);
                end
            end
        end
    end

    // Drive one cycle, check the combinational grant, queue the post-edge expectation.
    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                        input logic [31:0] data, input logic [3:0] exp_gnt,
                        input logic ev, input logic [7:0] eq, input logic [1:0] eown,
                        input logic elk);
        exp_t e;
        @(posedge clk);
        #2;
        reset  = rst;
        req_i  = req;
        lock_i = lock;
        data_i = data;
        #1;
        n_vec++;
        if (gnt_o !== exp_gnt) begin
            n_err++;
            $display("FAIL gnt: got %b want %b at %0t", gnt_o, exp_gnt, $time);
        end
        e.v   = ev;
        e.q   = eq;
        e.own = eown;
        e.lk  = elk;
        sb.push_back(e);
    endtask

    initial begin
        // Reset with all requests high
        step(1, 4'b1111, 4'b0000, D, 4'b0000, 0, 8'h00, 2'd0, 0);
        step(1, 4'b1111, 4'b0000, D, 4'b0000, 0, 8'h00, 2'd0, 0);
        // Single requester 2 with A5
        step(0, 4'b0100, 4'b0000, 32'h44A52211, 4'b0100, 1, 8'hA5, 2'd2, 0);
        // Re-reset so ptr restarts at 0
        step(1, 4'b1111, 4'b0000, D, 4'b0000, 0, 8'h00, 2'd0, 0);
        // Full contention: 0,1,2,3,0
        step(0, 4'b1111, 4'b0000, D, 4'b0001, 1, 8'h11, 2'd0, 0);
        step(0, 4'b1111, 4'b0000, D, 4'b0010, 1, 8'h22, 2'd1, 0);
        step(0, 4'b1111, 4'b0000, D, 4'b0100, 1, 8'h33, 2'd2, 0);
        step(0, 4'b1111, 4'b0000, D, 4'b1000, 1, 8'h44, 2'd3, 0);
        step(0, 4'b1111, 4'b0000, D, 4'b0001, 1, 8'h11, 2'd0, 0);
        // Lock by 1 from ptr=1: four writes then forced release, then 2
        step(0, 4'b1111, 4'b0010, D,  4'b0010, 1, 8'h22, 2'd1, 1);
        step(0, 4'b1111, 4'b0010, D,  4'b0010, 1, 8'h22, 2'd1, 1);
        step(0, 4'b1111, 4'b0010, D2, 4'b0010, 1, 8'hB2, 2'd1, 1);
        step(0, 4'b1111, 4'b0010, D,  4'b0010, 1, 8'h22, 2'd1, 0);
        step(0, 4'b1111, 4'b0010, D,  4'b0100, 1, 8'h33, 2'd2, 0);
        // Lock by 3, two writes, then req drop -> bubble, then grant 0
        step(0, 4'b1111, 4'b1000, D, 4'b1000, 1, 8'h44, 2'd3, 1);
        step(0, 4'b1111, 4'b1000, D, 4'b1000, 1, 8'h44, 2'd3, 1);
        step(0, 4'b0111, 4'b1000, D, 4'b0000, 0, 8'h44, 2'd3, 0);
        step(0, 4'b0111, 4'b0000, D, 4'b0001, 1, 8'h11, 2'd0, 0);
        // Voluntary release: lock_i drops on the final write
        step(0, 4'b1111, 4'b0010, D2, 4'b0010, 1, 8'hB2, 2'd1, 1);
        step(0, 4'b1111, 4'b0000, D,  4'b0010, 1, 8'h22, 2'd1, 0);
        step(0, 4'b1111, 4'b0000, D,  4'b0100, 1, 8'h33, 2'd2, 0);
        step(0, 4'b1111, 4'b0000, D,  4'b1000, 1, 8'h44, 2'd3, 0);
        // Lock by 0 from ptr=0, reset at cnt=2, then arbitration restarts at 0
        step(0, 4'b1111, 4'b0001, D, 4'b0001, 1, 8'h11, 2'd0, 1);
        step(0, 4'b1111, 4'b0001, D, 4'b0001, 1, 8'h11, 2'd0, 1);
        step(1, 4'b1111, 4'b0001, D, 4'b0000, 0, 8'h00, 2'd0, 0);
        step(0, 4'b1110, 4'b0000, D, 4'b0010, 1, 8'h22, 2'd1, 0);
        step(0, 4'b0000, 4'b1111, D, 4'b0000, 0, 8'h22, 2'd1, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
